// File: rtl/local_port_injector.sv
// Transmit half of the PE network interface: turns a (target, size) command and a
// payload word stream into a Hermes packet on the router LOCAL port under credit flow.
module local_port_injector #(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_target,
  input  logic [FLIT_WIDTH-1:0] cmd_size,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [FLIT_WIDTH-1:0] pay_data,
  output logic                  clock_tx,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_out,
  input  logic                  credit_i,
  output logic                  busy,
  output logic                  pkt_done
);

  localparam int unsigned IDX_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_WIDTH = IDX_WIDTH + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] SIZE    = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_n;
  logic [FLIT_WIDTH-1:0] size_q;
  logic [FLIT_WIDTH-1:0] size_n;
  logic [FLIT_WIDTH-1:0] remaining;
  logic [FLIT_WIDTH-1:0] remaining_n;
  logic                  tx_n;
  logic [FLIT_WIDTH-1:0] data_n;

  logic [FLIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr_n;
  logic [PTR_WIDTH-1:0]  rd_ptr_n;
  logic [FLIT_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  full_n;
  logic                  push;
  logic                  pop;
  logic                  xfer;
  logic                  accept;

  assign clock_tx   = clock;
  assign push       = pay_valid && pay_ready;
  assign accept     = cmd_valid && cmd_ready;
  assign xfer       = tx && credit_i;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_head  = fifo_mem[rd_ptr[IDX_WIDTH-1:0]];
  assign wr_ptr_n   = wr_ptr + PTR_WIDTH'(push);
  assign rd_ptr_n   = rd_ptr + PTR_WIDTH'(pop);

  // Fullness after this edge; pay_ready is registered from it so it is exact every cycle.
  assign full_n = (wr_ptr_n[IDX_WIDTH] != rd_ptr_n[IDX_WIDTH]) &&
                  (wr_ptr_n[IDX_WIDTH-1:0] == rd_ptr_n[IDX_WIDTH-1:0]);

  // Packet sequencer: next state, next flit on the wire, FIFO pop.
  always_comb begin
    state_n     = state;
    size_n      = size_q;
    remaining_n = remaining;
    tx_n        = tx;
    data_n      = data_out;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b0;
        if (accept) begin
          state_n = HEADER;
          size_n  = cmd_size;
          data_n  = FLIT_WIDTH'(cmd_target);
          tx_n    = 1'b1;
        end
      end
      HEADER: begin
        if (xfer) begin
          state_n = SIZE;
          data_n  = size_q;
        end
      end
      SIZE: begin
        if (xfer) begin
          if (size_q == '0) begin
            state_n = DONE;
            tx_n    = 1'b0;
          end else begin
            state_n     = PAYLOAD;
            remaining_n = size_q;
            tx_n        = !fifo_empty;
            pop         = !fifo_empty;
            if (!fifo_empty) begin
              data_n = fifo_head;
            end
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (remaining != '0) begin
            remaining_n = remaining - FLIT_WIDTH'(1);
          end
          if (remaining <= FLIT_WIDTH'(1)) begin
            state_n = DONE;
            tx_n    = 1'b0;
          end else begin
            tx_n = !fifo_empty;
            pop  = !fifo_empty;
            if (!fifo_empty) begin
              data_n = fifo_head;
            end
          end
        end else if (!tx && !fifo_empty) begin
          // Starved bubble ends: present the word that just arrived.
          pop    = 1'b1;
          tx_n   = 1'b1;
          data_n = fifo_head;
        end
      end
      DONE: begin
        state_n = IDLE;
        tx_n    = 1'b0;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      size_q    <= '0;
      remaining <= '0;
      tx        <= 1'b0;
      data_out  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_ready <= 1'b0;
      pay_ready <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state     <= state_n;
      size_q    <= size_n;
      remaining <= remaining_n;
      tx        <= tx_n;
      data_out  <= data_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      cmd_ready <= (state_n == IDLE);
      pay_ready <= !full_n;
      busy      <= (state_n == HEADER) || (state_n == SIZE) || (state_n == PAYLOAD);
      pkt_done  <= (state_n == DONE);
    end
  end

  // Payload storage; writes are gated by pay_ready, which is low throughout reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr[IDX_WIDTH-1:0]] <= pay_data;
    end
  end

endmodule

// File: tb/tb_local_port_injector.sv
// Directed bench for local_port_injector: a packet-level model predicts every
// transferred flit and pkt_done pulse; literal flit lists pin each scenario.
module tb_local_port_injector;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [15:0] cmd_size;
  logic        pay_valid;
  logic        pay_ready;
  logic [15:0] pay_data;
  logic        clock_tx;
  logic        tx;
  logic [15:0] data_out;
  logic        credit_i;
  logic        busy;
  logic        pkt_done;

  int vec_count = 0;
  int err_count = 0;

  local_port_injector #(.FLIT_WIDTH(16), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target), .cmd_size(cmd_size),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .clock_tx(clock_tx), .tx(tx), .data_out(data_out), .credit_i(credit_i),
    .busy(busy), .pkt_done(pkt_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] want);
    vec_count++;
    if (act !== want) begin
      err_count++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, want);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic want);
    vec_count++;
    if (act !== want) begin
      err_count++;
      $display("FAIL %s: got %b expected %b", name, act, want);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    vec_count++;
    if (act != want) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Packet-level model: phase 0 idle, 1 header due, 2 size due, 3 payload due.
  int          phase = 0;
  int          owed = 0;
  int          cyc = 0;
  logic [7:0]  m_tgt = '0;
  logic [15:0] m_size = '0;
  logic        done_due = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0] exp_w;
  logic [15:0] pay_q[$];
  logic [15:0] log_q[$];
  int          log_cyc[$];

  // Sampled mid-cycle: values seen here are what the next rising edge acts on.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      phase      = 0;
      owed       = 0;
      done_due   = 1'b0;
      prev_stall = 1'b0;
      pay_q.delete();
    end else begin
      check1("pkt_done", pkt_done, done_due);
      done_due = 1'b0;
      if (pkt_done && tx) begin
        vec_count++;
        err_count++;
        $display("FAIL done_with_tx: got tx=1 with pkt_done=1 expected tx=0");
      end
      if (prev_stall) begin
        check1("hold_tx", tx, 1'b1);
        check16("hold_data", data_out, prev_data);
      end
      if (phase == 0) begin
        check1("tx_idle", tx, 1'b0);
      end else if (tx && credit_i) begin
        log_q.push_back(data_out);
        log_cyc.push_back(cyc);
        case (phase)
          1: begin
            check16("header", data_out, {8'h00, m_tgt});
            phase = 2;
          end
          2: begin
            check16("size", data_out, m_size);
            if (m_size == 16'd0) begin
              phase    = 0;
              done_due = 1'b1;
            end else begin
              owed  = int'(m_size);
              phase = 3;
            end
          end
          default: begin
            if (pay_q.size() == 0) begin
              vec_count++;
              err_count++;
              $display("FAIL payload_source: got 0x%04h expected no flit (no word supplied)", data_out);
            end else begin
              exp_w = pay_q.pop_front();
              check16("payload", data_out, exp_w);
            end
            owed--;
            if (owed == 0) begin
              phase    = 0;
              done_due = 1'b1;
            end
          end
        endcase
      end
      prev_stall = tx && !credit_i;
      prev_data  = data_out;
      if (cmd_valid && cmd_ready) begin
        phase  = 1;
        m_tgt  = cmd_target;
        m_size = cmd_size;
      end
      if (pay_valid && pay_ready) pay_q.push_back(pay_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    check1("push_pay_ready", pay_ready, 1'b1);
    pay_valid = 1'b1;
    pay_data  = w;
    tick(1);
    pay_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] t, input logic [15:0] s);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!cmd_ready) begin
      vec_count++;
      err_count++;
      $display("FAIL cmd_ready_wait: got 0 after %0d cycles expected 1", n);
    end
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_size   = s;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!pkt_done && n < 200) begin
      tick(1);
      n++;
    end
    check1("pkt_done_seen", pkt_done, 1'b1);
  endtask

  task automatic check_log(input string name, input int start, input int n, input logic [15:0] want [8]);
    for (int i = 0; i < n; i++) begin
      if (start + i >= log_q.size()) begin
        vec_count++;
        err_count++;
        $display("FAIL %s[%0d]: got no flit expected 0x%04h", name, i, want[i]);
      end else begin
        check16(name, log_q[start + i], want[i]);
      end
    end
    check_int({name, "_count"}, log_q.size() - start, n);
  endtask

  initial begin
    int mark;
    int n;
    reset      = 1'b0;
    cmd_valid  = 1'b1;
    cmd_target = 8'h55;
    cmd_size   = 16'd7;
    pay_valid  = 1'b0;
    pay_data   = '0;
    credit_i   = 1'b1;

    // Reset with a stale command pending
    tick(3);
    check1("rst_tx", tx, 1'b0);
    check16("rst_data", data_out, 16'h0000);
    check1("rst_cmd_ready", cmd_ready, 1'b0);
    check1("rst_pay_ready", pay_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_pkt_done", pkt_done, 1'b0);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    tick(1);
    check1("rel_cmd_ready", cmd_ready, 1'b1);
    check1("rel_pay_ready", pay_ready, 1'b1);
    check1("clock_tx", clock_tx, clock);
    tick(3);
    check1("rel_tx", tx, 1'b0);
    check1("rel_busy", busy, 1'b0);

    // Nominal packet with preloaded payload
    push_word(16'hA001);
    push_word(16'hA002);
    push_word(16'hA003);
    mark = log_q.size();
    send_cmd(8'h11, 16'd3);
    wait_done();
    check1("done_busy", busy, 1'b0);
    check1("done_tx", tx, 1'b0);
    check1("done_cmd_ready", cmd_ready, 1'b0);
    check_log("nominal", mark, 5, '{16'h0011, 16'h0003, 16'hA001, 16'hA002, 16'hA003, 16'h0, 16'h0, 16'h0});
    if (log_cyc.size() >= mark + 5) check_int("nominal_back_to_back", log_cyc[mark + 4] - log_cyc[mark], 4);
    tick(1);
    check1("post_cmd_ready", cmd_ready, 1'b1);

    // Back-pressure on the size flit
    push_word(16'hC001);
    push_word(16'hC002);
    push_word(16'hC003);
    mark = log_q.size();
    send_cmd(8'h44, 16'd3);
    check1("bp_hdr_tx", tx, 1'b1);
    check16("bp_hdr", data_out, 16'h0044);
    tick(1);
    credit_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("bp_tx", tx, 1'b1);
      check16("bp_hold", data_out, 16'h0003);
      check1("bp_busy", busy, 1'b1);
      tick(1);
    end
    credit_i = 1'b1;
    wait_done();
    check_log("backpressure", mark, 5, '{16'h0044, 16'h0003, 16'hC001, 16'hC002, 16'hC003, 16'h0, 16'h0, 16'h0});

    // Zero payload leaves prefetched words for the next packet
    push_word(16'hD001);
    push_word(16'hD002);
    mark = log_q.size();
    send_cmd(8'h22, 16'd0);
    wait_done();
    check_log("zero", mark, 2, '{16'h0022, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    check1("zero_pay_ready", pay_ready, 1'b1);
    mark = log_q.size();
    send_cmd(8'h23, 16'd2);
    wait_done();
    check_log("after_zero", mark, 4, '{16'h0023, 16'h0002, 16'hD001, 16'hD002, 16'h0, 16'h0, 16'h0, 16'h0});

    // Starvation: payload arrives well after the size flit
    mark = log_q.size();
    send_cmd(8'h5A, 16'd2);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      check1("starve_tx", tx, 1'b0);
      check1("starve_busy", busy, 1'b1);
      tick(1);
    end
    push_word(16'hB001);
    check1("starve_bubble", tx, 1'b0);
    push_word(16'hB002);
    check1("starve_resume_tx", tx, 1'b1);
    check16("starve_resume", data_out, 16'hB001);
    wait_done();
    check_log("starve", mark, 4, '{16'h005A, 16'h0002, 16'hB001, 16'hB002, 16'h0, 16'h0, 16'h0, 16'h0});

    // Fill the FIFO while idle
    push_word(16'hE001);
    push_word(16'hE002);
    push_word(16'hE003);
    push_word(16'hE004);
    check1("full_pay_ready", pay_ready, 1'b0);
    pay_valid = 1'b1;
    pay_data  = 16'hEEEE;
    tick(1);
    pay_valid = 1'b0;
    check1("full_hold", pay_ready, 1'b0);

    // Reset after the second payload flit of a 5-flit packet
    mark = log_q.size();
    send_cmd(8'h66, 16'd5);
    n = 0;
    while (log_q.size() < mark + 4 && n < 50) begin
      tick(1);
      n++;
    end
    check_int("mid_progress", log_q.size() - mark, 4);
    reset = 1'b0;
    tick(1);
    check1("mid_rst_tx", tx, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_pkt_done", pkt_done, 1'b0);
    check1("mid_rst_cmd_ready", cmd_ready, 1'b0);
    reset = 1'b1;
    tick(1);
    check1("mid_rel_cmd_ready", cmd_ready, 1'b1);
    check1("mid_rel_pay_ready", pay_ready, 1'b1);
    check_log("mid_reset", mark, 4, '{16'h0066, 16'h0005, 16'hE001, 16'hE002, 16'h0, 16'h0, 16'h0, 16'h0});
    push_word(16'hF001);
    mark = log_q.size();
    send_cmd(8'h77, 16'd1);
    wait_done();
    check_log("post_reset", mark, 3, '{16'h0077, 16'h0001, 16'hF001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/local_port_injector.md
Name: local_port_injector

Overview:
- Packet injector sitting directly upstream of the router's LOCAL input port. It is the transmit half of the processing-element network interface.
- Accepts a packet command (target address, payload size) and a stream of payload words from the core side.
- Emits a Hermes-format packet (header flit, size flit, payload flits) on the router-facing port under credit-based flow control.
- Decouples the core from network back-pressure with a small payload FIFO.

Parameters:
- FLIT_WIDTH, 16, width of one flit (matches router TAM_FLIT).
- ADDR_WIDTH, 8, width of target address field (FLIT_WIDTH/2; router XY address).
- FIFO_DEPTH, 4, payload FIFO entries; power of two, >= 2.

Ports:
- clock, in, 1, single clock for the whole block.
- reset, in, 1, synchronous, active-low reset.
- cmd_valid, in, 1, packet command present.
- cmd_ready, out, 1, block can accept a command.
- cmd_target, in, ADDR_WIDTH, destination router address.
- cmd_size, in, FLIT_WIDTH, payload length in flits (0 legal).
- pay_valid, in, 1, payload word present.
- pay_ready, out, 1, payload FIFO not full.
- pay_data, in, FLIT_WIDTH, payload word.
- clock_tx, out, 1, forwarded clock to router (equals clock).
- tx, out, 1, flit valid toward router LOCAL rx.
- data_out, out, FLIT_WIDTH, flit toward router LOCAL data_in.
- credit_i, in, 1, router LOCAL credit_o; 1 = buffer space available.
- busy, out, 1, packet in progress.
- pkt_done, out, 1, one-cycle pulse after last flit transferred.

Behaviour:
- Reset: sampled on rising clock edge while reset=0.
  - Values held during reset: tx=0, data_out=0, cmd_ready=0, pay_ready=0, busy=0, pkt_done=0.
  - FIFO emptied, remaining-count counter cleared, FSM to IDLE.
- Transfer rule:
  - A flit moves on a rising edge with tx=1 and credit_i=1.
  - While tx=1 and credit_i=0, tx and data_out hold unchanged; no flit is duplicated or dropped.
  - tx and data_out are registered outputs.
- Command handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on an edge with cmd_valid=1 and cmd_ready=1; target and size are captured.
- Payload handshake:
  - pay_ready = FIFO not full, in every state after reset (prefetch while IDLE allowed).
  - A word is written on an edge with pay_valid=1 and pay_ready=1.
  - A simultaneous FIFO read and write while full is not allowed; pay_ready gates the write.
- FSM:
  - IDLE: on command accept -> HEADER. data_out <= zero-extended cmd_target, tx <= 1, busy <= 1. Header appears the cycle after accept.
  - HEADER: on transfer -> SIZE. data_out <= cmd_size, tx stays 1.
  - SIZE: on transfer:
    - if size=0 -> DONE, tx <= 0;
    - else -> PAYLOAD; load remaining count = size; present FIFO head if non-empty (pop, tx <= 1), else tx <= 0.
  - PAYLOAD:
    - Each transfer decrements the count and pops the next word when available.
    - FIFO empty -> tx=0 bubble until a word arrives; the word is then presented the next cycle.
    - On transfer with count=1 -> DONE, tx <= 0.
  - DONE: one cycle; pkt_done=1, busy=0 -> IDLE (cmd_ready=1 the following cycle).
- Width rules:
  - The header flit's upper FLIT_WIDTH-ADDR_WIDTH bits are 0.
  - The count is FLIT_WIDTH bits and never wraps: decrement only on payload transfer with count >= 1.
- FIFO pointers: log2(FIFO_DEPTH) bits plus a wrap bit. Full/empty come from pointer compare; pointers wrap naturally.
- Excess payload words beyond cmd_size stay in the FIFO for the next packet.
- Reset mid-packet: tx drops to 0 at the reset edge; the packet is truncated; the FIFO is flushed.
- Invariants:
  - tx never asserted in IDLE or DONE.
  - At most one flit per clock.
  - pkt_done never asserted with tx=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 -> tx=0, data_out=0, cmd_ready=0; after release cmd_ready=1, no packet started from the stale command.
- Nominal packet: target 0x11, size 3, payload 0xA001,0xA002,0xA003 preloaded, credit_i=1 -> data_out 0x0011,0x0003,0xA001,0xA002,0xA003 on 5 consecutive transfer cycles, then pkt_done pulse, then cmd_ready=1.
- Back-pressure: credit_i=0 for 3 cycles while the size flit is presented -> tx=1, data_out=0x0003 stable for all 3 cycles; exactly one 0x0003 transferred; the sequence continues unchanged.
- Zero payload: target 0x22, size 0 -> exactly two flits, 0x0022 then 0x0000, then pkt_done; FIFO contents untouched.
- Starvation: size 2, first word supplied 4 cycles after the size flit -> tx=0 during the gap, then 0xB001, 0xB002 transferred; FIFO full (4 words) -> pay_ready=0.
- Reset mid-payload: reset=0 after the 2nd of 5 payload flits -> tx=0 the next cycle, busy=0, FIFO empty; a new command is sent cleanly afterward.
